// File: rtl/msip_seq_ctrl.sv
// msip_seq_ctrl
//   Single-clock sequencer for the multispeed inner-product generator.
//   It drives two LFSRs through clock enables: the fast one (lf2) steps on
//   every enabled cycle and the slow one (lf1) on every DIV-th. After seeding
//   it discards WARMUP enabled cycles, then packs the serial gout bit into
//   32-bit words and hands them out over valid/ready. If a word is pending
//   when the next one completes, the generator is frozen, so the word stream
//   never depends on consumer timing.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   start, abort           begin a run (IDLE only) / cancel a run
//   num_words, seed1/2     run parameters, latched on start
//   gout                   generator output bit from the datapath
//   ld, lf1_seed, lf2_seed seed-load pulse and latched seeds (0 -> 1)
//   lf1_en, lf2_en         slow/fast LFSR step enables
//   word_o, word_valid,
//   word_ready             output word handshake
//   busy, done             not-IDLE flag / one-cycle completion pulse
module msip_seq_ctrl #(
    parameter int DIV    = 10,
    parameter int WARMUP = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic [31:0]      seed1,
    input  logic [31:0]      seed2,
    input  logic             gout,
    output logic             ld,
    output logic [31:0]      lf1_seed,
    output logic [31:0]      lf2_seed,
    output logic             lf1_en,
    output logic             lf2_en,
    output logic [31:0]      word_o,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W  = $clog2(DIV);
    localparam int WARM_W = $clog2(WARMUP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic [4:0]         r_bit_cnt;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_num_words;
    logic [30:0]        r_sr;

    logic               w_stall;
    logic               w_step;
    logic               w_div_wrap;
    logic               w_word_done;
    logic               w_last;
    logic               w_accept;
    logic               w_abort;
    logic [CNT_W-1:0]   w_word_cnt_nxt;

    // The only stall point is completing a word while the previous one is
    // still unaccepted; everything upstream simply freezes.
    assign w_stall        = (r_state == S_RUN) && (r_bit_cnt == 5'd31) &&
                            word_valid && !word_ready;
    assign w_abort        = abort && (r_state != S_IDLE);
    assign w_step         = ((r_state == S_WARM) || (r_state == S_RUN)) &&
                            !w_stall && !w_abort;
    assign w_div_wrap     = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_word_done    = (r_state == S_RUN) && w_step && (r_bit_cnt == 5'd31);
    assign w_word_cnt_nxt = r_word_cnt + 1'b1;
    assign w_last         = w_word_done && (w_word_cnt_nxt == r_num_words);
    assign w_accept       = word_valid && word_ready;

    assign lf2_en = w_step;
    assign lf1_en = w_step && w_div_wrap;
    assign ld     = (r_state == S_LOAD);
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (num_words == '0) ? S_DONE : S_LOAD;
            S_LOAD:  w_next = S_WARM;
            S_WARM:  if (w_step && (r_warm_cnt == WARM_W'(WARMUP - 1))) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_warm_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_num_words <= '0;
            r_sr        <= '0;
            lf1_seed    <= '0;
            lf2_seed    <= '0;
            word_o      <= '0;
            word_valid  <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && start) begin
                r_num_words <= num_words;
                // An all-zero LFSR state would lock up, so substitute 1.
                lf1_seed    <= (seed1 == 32'd0) ? 32'd1 : seed1;
                lf2_seed    <= (seed2 == 32'd0) ? 32'd1 : seed2;
            end

            if (r_state == S_LOAD) begin
                r_div_cnt  <= '0;
                r_warm_cnt <= '0;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end

            if (w_step) begin
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                if (r_state == S_WARM) r_warm_cnt <= r_warm_cnt + 1'b1;
                if (r_state == S_RUN) begin
                    r_sr      <= {r_sr[29:0], gout};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd31) begin
                        // First sampled bit has shifted up to bit 31.
                        word_o     <= {r_sr, gout};
                        r_word_cnt <= w_word_cnt_nxt;
                    end
                end
            end

            // A new word landing on the acceptance cycle keeps valid high.
            if (w_abort)          word_valid <= 1'b0;
            else if (w_word_done) word_valid <= 1'b1;
            else if (w_accept)    word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msip_seq_ctrl.sv
module tb_msip_seq_ctrl;

    localparam int DIV    = 10;
    localparam int WARMUP = 64;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst, start, abort, gout, word_ready;
    logic [CNT_W-1:0] num_words;
    logic [31:0]      seed1, seed2;
    logic             ld, lf1_en, lf2_en, word_valid, busy, done;
    logic [31:0]      lf1_seed, lf2_seed, word_o;

    msip_seq_ctrl #(.DIV(DIV), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_words(num_words), .seed1(seed1), .seed2(seed2), .gout(gout),
        .ld(ld), .lf1_seed(lf1_seed), .lf2_seed(lf2_seed),
        .lf1_en(lf1_en), .lf2_en(lf2_en), .word_o(word_o),
        .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator datapath: two Galois LFSRs, ANDed and XOR-reduced.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    logic [31:0] r1, r2;
    always @(posedge clk) begin
        if (rst) begin
            r1 <= '0;
            r2 <= '0;
        end else if (ld) begin
            r1 <= lf1_seed;
            r2 <= lf2_seed;
        end else begin
            if (lf1_en) r1 <= lfsr_step(r1);
            if (lf2_en) r2 <= lfsr_step(r2);
        end
    end
    assign gout = ^(r1 & r2);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: word stream as a function of seeds only. At the k-th
    // enabled cycle after seeding, lf2 has stepped k times and lf1 k/DIV times.
    logic [31:0] exp_w [8];
    logic [31:0] got_w [8];
    logic [31:0] base_w [8];
    logic [31:0] exp_s1, exp_s2;
    int          exp_n = 0;
    int          acc_idx = 0;

    task automatic compute_words(input logic [31:0] s1, input logic [31:0] s2, input int n);
        logic [31:0] a, b, cur;
        int j;
        a = s1; b = s2; cur = '0;
        for (int k = 0; k < WARMUP + 32 * n; k++) begin
            if (k >= WARMUP) begin
                j = k - WARMUP;
                cur = {cur[30:0], ^(a & b)};
                if (j % 32 == 31) exp_w[j / 32] = cur;
            end
            b = lfsr_step(b);
            if (k % DIV == DIV - 1) a = lfsr_step(a);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin : compare
        int k;
        bit hold;
        logic [31:0] hold_w;
        bit stall_exp;
        k = 0; hold = 0; hold_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (!busy) begin
                    chk("idle_en", {29'd0, ld, lf1_en, lf2_en}, 32'd0);
                end
                if (ld) begin
                    k = 0;
                    chk("lf1_seed", lf1_seed, exp_s1);
                    chk("lf2_seed", lf2_seed, exp_s2);
                end
                if (hold) begin
                    chk("hold_valid", word_valid, 1);
                    chk("hold_word", word_o, hold_w);
                end
                stall_exp = busy && word_valid && !word_ready && k >= WARMUP &&
                            k < WARMUP + 32 * exp_n && ((k - WARMUP) % 32 == 31);
                if (stall_exp) chk("stall_freeze", {30'd0, lf1_en, lf2_en}, 32'd0);
                if (lf1_en && !lf2_en) chk("lf1_without_lf2", lf1_en, 0);
                if (lf2_en) begin
                    chk("lf1_phase", lf1_en, (k % DIV == DIV - 1));
                    k++;
                end
                if (word_valid && word_ready) begin
                    if (acc_idx < exp_n) begin
                        chk("word", word_o, exp_w[acc_idx]);
                        got_w[acc_idx] = word_o;
                    end else begin
                        chk("extra_word", acc_idx, exp_n - 1);
                    end
                    acc_idx++;
                end
                hold   = word_valid && !word_ready && !abort;
                hold_w = word_o;
            end
        end
    end

    task automatic run(input logic [31:0] s1, input logic [31:0] s2, input int n,
                       input int rmode, input bit timing, input int abort_at,
                       input bit busy_start, input int rst_at);
        int T, rel, done_rel;
        @(posedge clk); #1;
        exp_s1 = (s1 == 0) ? 32'd1 : s1;
        exp_s2 = (s2 == 0) ? 32'd1 : s2;
        compute_words(exp_s1, exp_s2, n);
        exp_n = n; acc_idx = 0;
        seed1 = s1; seed2 = s2; num_words = CNT_W'(n); start = 1;
        word_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        T = cyc; done_rel = -1;
        forever begin
            @(negedge clk);
            rel = cyc - T;
            if (timing) begin
                chk("t_ld", ld, rel == 1);
                chk("t_lf2_en", lf2_en, rel >= 2 && rel <= 1 + WARMUP + 32 * n);
                chk("t_lf1_en", lf1_en, rel >= 2 && rel <= 1 + WARMUP + 32 * n &&
                                        ((rel - 2) % DIV == DIV - 1));
                chk("t_valid", word_valid, rel == 2 + WARMUP + 32 || rel == 2 + WARMUP + 64);
                chk("t_done", done, rel == 3 + WARMUP + 32 * n);
            end
            if (n == 0) chk("zero_n_en", {30'd0, ld, lf2_en}, 32'd0);
            if (abort_at >= 0 && rel == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", word_valid, 0);
                chk("abort_done", done, 0);
                chk("abort_no_done_before", done_rel, -1);
                break;
            end
            if (rst_at >= 0 && rel == rst_at + 3) begin
                chk("rst_outs", {ld, lf1_en, lf2_en, word_valid, busy, done}, 0);
                chk("rst_word", word_o, 0);
                chk("rst_seed1", lf1_seed, 0);
                chk("rst_seed2", lf2_seed, 0);
                break;
            end
            if (done) done_rel = rel;
            if (done_rel >= 0) break;
            if (rel > 3000) begin
                chk("timeout", rel, 0);
                break;
            end
            @(posedge clk); #1;
            rel = cyc - T;
            start     = busy_start && rel == 40;
            num_words = (busy_start && rel == 40) ? CNT_W'(5) : CNT_W'(n);
            abort     = (rel == abort_at);
            rst       = rst_at >= 0 && rel >= rst_at && rel < rst_at + 3;
            case (rmode)
                0:       word_ready = 1'b1;
                1:       word_ready = (rel >= 100 && rel < 150) ? 1'b0 : 1'($urandom_range(0, 1));
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
        end
        if (abort_at < 0 && rst_at < 0) begin
            chk("word_count", acc_idx, n);
            if (rmode == 0) chk("done_time", done_rel, (n == 0) ? 1 : 3 + WARMUP + 32 * n);
        end
        @(posedge clk); #1;
        start = 0; abort = 0; rst = 0; word_ready = 1;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; word_ready = 1;
        num_words = '0; seed1 = '0; seed2 = '0;
        exp_s1 = '0; exp_s2 = '0;

        // Pin the model's primitives.
        chk("pin_step1", lfsr_step(32'h1), 32'hA300_0000);
        chk("pin_step2", lfsr_step(32'hA300_0000), 32'h5180_0000);
        chk("pin_step3", lfsr_step(32'h2), 32'h1);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outs", {ld, lf1_en, lf2_en, word_valid, busy, done}, 0);
        chk("reset_word", word_o, 0);
        chk("reset_seed1", lf1_seed, 0);

        // Basic run with exact timing.
        run(32'hACE1_0001, 32'h1234_5678, 2, 0, 1, -1, 0, -1);
        for (int i = 0; i < 2; i++) base_w[i] = got_w[i];

        // Backpressure: same words regardless of ready pattern.
        run(32'hACE1_0001, 32'h1234_5678, 2, 1, 0, -1, 0, -1);
        for (int i = 0; i < 2; i++) chk("bp_identical", got_w[i], base_w[i]);

        // Zero seed substitution.
        run(32'h0, 32'h1234_5678, 1, 0, 0, -1, 0, -1);

        // Abort at bit_cnt 17, then restart reproduces the stream.
        run(32'hACE1_0001, 32'h1234_5678, 3, 0, 0, 2 + WARMUP + 17, 0, -1);
        run(32'hACE1_0001, 32'h1234_5678, 2, 0, 0, -1, 0, -1);
        for (int i = 0; i < 2; i++) chk("abort_restart", got_w[i], base_w[i]);

        // num_words = 0.
        run(32'h5, 32'h7, 0, 0, 0, -1, 0, -1);

        // start while busy is ignored (timing and word count unchanged).
        run(32'hACE1_0001, 32'h1234_5678, 2, 0, 1, -1, 1, -1);

        // Reset mid-RUN for 3 cycles.
        run(32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 0, 0, -1, 0, 80);

        // Random seeds, counts and ready.
        for (int r = 0; r < 4; r++)
            run($urandom, $urandom, $urandom_range(1, 3), 2, 0, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
